rv32i_alu_arbiter: RTL and testbench

Shares the single RV32I ALU between two requesters: port 0 is the core execute stage, port 1 is the debug/peripheral engine. Each request carries a 4-bit opcode and two operands. The block round-robin arbitrates between the two ports, registers the operands and the one-hot ALU op lines, drives the ALU for one cycle, and returns the captured result on a per-port valid/ready response channel. It sits between the requesters and the ALU and owns every ALU input.

---
 rtl/rv32i_alu_arbiter.sv | 87 ++++++++
 tb/tb_rv32i_alu_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rv32i_alu_arbiter.sv
// rv32i_alu_arbiter: round-robin sharing of one RV32I ALU between two requesters with per-port responses
module rv32i_alu_arbiter #(
  parameter logic RR_INIT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [3:0]  req0_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [3:0]  req1_op_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  output logic        resp0_valid_o,
  input  logic        resp0_ready_i,
  output logic [31:0] resp0_data_o,
  output logic        resp0_err_o,
  output logic        resp1_valid_o,
  input  logic        resp1_ready_i,
  output logic [31:0] resp1_data_o,
  output logic        resp1_err_o,
  output logic [31:0] alu_rsa_o,
  output logic [31:0] alu_rsb_imm_o,
  output logic [15:0] alu_op_o,
  input  logic [31:0] alu_dout_i
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state_q, state_d;
  logic        last_q, owner_q, err_q;
  logic [31:0] result_q, rsa_q, rsb_q;
  logic [15:0] op_q;
  logic        idle, grant1, hs, resp_hs;
  logic [3:0]  sel_op;
  assign idle          = state_q == IDLE && !rst_i;
  assign grant1        = req1_valid_i && (!req0_valid_i || !last_q);
  assign req0_ready_o  = idle && req0_valid_i && !grant1;
  assign req1_ready_o  = idle && grant1;
  assign hs            = req0_ready_o || req1_ready_o;
  assign sel_op        = grant1 ? req1_op_i : req0_op_i;
  assign resp0_valid_o = state_q == RESP && !owner_q;
  assign resp1_valid_o = state_q == RESP && owner_q;
  assign resp0_data_o  = resp0_valid_o ? result_q : '0;
  assign resp1_data_o  = resp1_valid_o ? result_q : '0;
  assign resp0_err_o   = resp0_valid_o && err_q;
  assign resp1_err_o   = resp1_valid_o && err_q;
  assign resp_hs       = (resp0_valid_o && resp0_ready_i) || (resp1_valid_o && resp1_ready_i);
  assign alu_rsa_o     = rsa_q;
  assign alu_rsb_imm_o = rsb_q;
  assign alu_op_o      = op_q;
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (hs ? EXEC : IDLE) :
              state_q == EXEC ? RESP : (resp_hs ? IDLE : RESP);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_q   <= RR_INIT;
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      rsa_q    <= '0;
      rsb_q    <= '0;
      op_q     <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        rsa_q   <= grant1 ? req1_a_i : req0_a_i;
        rsb_q   <= grant1 ? req1_b_i : req0_b_i;
        op_q    <= sel_op == 4'd15 ? 16'd0 : 16'd1 << sel_op;
        err_q   <= sel_op == 4'd15;
        owner_q <= grant1;
      end
      if (state_q == EXEC) begin
        result_q <= err_q ? '0 : alu_dout_i;
        op_q     <= '0;
      end
      if (resp_hs) begin
        last_q <= owner_q;
        err_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// tb_rv32i_alu_arbiter: directed self-checking bench with a behavioural ALU model
module tb_rv32i_alu_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0]  req0_op = 0, req1_op = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        resp0_valid, resp1_valid, resp0_ready = 1, resp1_ready = 1;
  logic [31:0] resp0_data, resp1_data, alu_rsa, alu_rsb, alu_dout;
  logic        resp0_err, resp1_err;
  logic [15:0] alu_op;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  rv32i_alu_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op), .req0_a_i(req0_a), .req0_b_i(req0_b),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op), .req1_a_i(req1_a), .req1_b_i(req1_b),
    .resp0_valid_o(resp0_valid), .resp0_ready_i(resp0_ready), .resp0_data_o(resp0_data), .resp0_err_o(resp0_err),
    .resp1_valid_o(resp1_valid), .resp1_ready_i(resp1_ready), .resp1_data_o(resp1_data), .resp1_err_o(resp1_err),
    .alu_rsa_o(alu_rsa), .alu_rsb_imm_o(alu_rsb), .alu_op_o(alu_op), .alu_dout_i(alu_dout)
  );
  function automatic logic [31:0] alu_m(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      16'h0001: return a + b;
      16'h0002: return a - b;
      16'h0004: return a & b;
      16'h0008: return a | b;
      16'h0010: return a ^ b;
      16'h0020: return a << b[4:0];
      16'h0040: return a >> b[4:0];
      16'h0080: return $signed(a) >>> b[4:0];
      16'h0100: return a == b ? '1 : '0;
      16'h0200: return a != b ? '1 : '0;
      16'h0400: return $signed(a) < $signed(b) ? '1 : '0;
      16'h0800: return $signed(a) >= $signed(b) ? '1 : '0;
      16'h1000: return a < b ? '1 : '0;
      16'h2000: return a >= b ? '1 : '0;
      16'h4000: return b;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction
  assign alu_dout = alu_m(alu_op, alu_rsa, alu_rsb);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, {30'd0, req1_ready, req0_ready}, 0);
    chk({tag, "_rv"}, {30'd0, resp1_valid, resp0_valid}, 0);
    chk({tag, "_re"}, {30'd0, resp1_err, resp0_err}, 0);
    chk({tag, "_rd0"}, resp0_data, 0);
    chk({tag, "_rd1"}, resp1_data, 0);
    chk({tag, "_rsa"}, alu_rsa, 0);
    chk({tag, "_rsb"}, alu_rsb, 0);
    chk({tag, "_op"}, {16'd0, alu_op}, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    req0_valid = 1; req0_op = 4'd1; req0_a = 3; req0_b = 5;
    req1_valid = 1; req1_op = 4'd5; req1_a = 1; req1_b = 33;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_rdy0", {31'd0, req0_ready}, (i % 2) == 0);
      chk("rr_rdy1", {31'd0, req1_ready}, (i % 2) == 1);
      repeat (2) @(negedge clk);
      chk("rr_v0", {31'd0, resp0_valid}, (i % 2) == 0);
      chk("rr_v1", {31'd0, resp1_valid}, (i % 2) == 1);
      chk("rr_data", (i % 2) ? resp1_data : resp0_data, (i % 2) ? 32'h0000_0002 : 32'hFFFF_FFFE);
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    req0_valid = 1; req0_op = 4'd0; req0_a = 5; req0_b = 7;
    #1 chk("add_rdy0", {31'd0, req0_ready}, 1);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    chk("add_op", {16'd0, alu_op}, 1);
    chk("add_rsa", alu_rsa, 5);
    chk("add_rsb", alu_rsb, 7);
    @(negedge clk);
    chk("add_v0", {31'd0, resp0_valid}, 1);
    chk("add_data", resp0_data, 32'h0000_000C);
    chk("add_err", {31'd0, resp0_err}, 0);
    chk("add_v1", {31'd0, resp1_valid}, 0);
    @(negedge clk);
    chk("add_vdrop", {31'd0, resp0_valid}, 0);
    resp1_ready = 0;
    req1_valid = 1; req1_op = 4'd12; req1_a = 1; req1_b = 32'hFFFF_FFFF;
    req0_valid = 1; req0_op = 4'd15; req0_a = 9; req0_b = 9;
    #1 chk("bp_rdy1", {31'd0, req1_ready}, 1);
    chk("bp_rdy0_idle", {31'd0, req0_ready}, 0);
    @(posedge clk); #1 req1_valid = 0;
    @(negedge clk);
    chk("bp_rdy0_exec", {31'd0, req0_ready}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_v1", {31'd0, resp1_valid}, 1);
      chk("bp_data", resp1_data, 32'hFFFF_FFFF);
      chk("bp_rdy0", {31'd0, req0_ready}, 0);
    end
    resp1_ready = 1;
    @(negedge clk);
    chk("bp_vdrop", {31'd0, resp1_valid}, 0);
    chk("res_rdy0", {31'd0, req0_ready}, 1);
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    chk("res_op_exec", {16'd0, alu_op}, 0);
    @(negedge clk);
    chk("res_op_resp", {16'd0, alu_op}, 0);
    chk("res_v0", {31'd0, resp0_valid}, 1);
    chk("res_data", resp0_data, 0);
    chk("res_err", {31'd0, resp0_err}, 1);
    @(negedge clk);
    req0_valid = 1; req0_op = 4'd4; req0_a = 32'hF0; req0_b = 32'hFF;
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    chk("xor_op", {16'd0, alu_op}, 16'h0010);
    @(negedge clk);
    chk("xor_data", resp0_data, 32'h0F);
    chk("xor_err", {31'd0, resp0_err}, 0);
    @(negedge clk);
    req0_valid = 1; req0_op = 4'd0; req0_a = 10; req0_b = 20;
    req1_valid = 1; req1_op = 4'd2; req1_a = 32'hFF; req1_b = 32'h0F;
    #1 chk("rst_rdy1", {31'd0, req1_ready}, 1);
    @(negedge clk);
    chk("rst_exec_op", {16'd0, alu_op}, 16'h0004);
    rst = 1;
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 0;
    #1 chk("rst_tie0", {31'd0, req0_ready}, 1);
    chk("rst_tie1", {31'd0, req1_ready}, 0);
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("rst_nostale", {30'd0, resp1_valid, resp0_valid}, 0);
    @(negedge clk);
    chk("rst_v", {30'd0, resp1_valid, resp0_valid}, 2'b01);
    chk("rst_data", resp0_data, 30);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
